// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: register/word types, load funct3 encoding, writeback
// request record and the load extension helper used at LSU push time.
package wb_arbiter_pkg;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_t;

    typedef struct packed {
        reg_addr_t rd;
        word_t     data;
    } wb_req_t;

    // Reserved funct3 codes fall through to the unmodified word.
    function automatic word_t load_extend(input word_t raw, input load_f3_t f3,
                                          input logic [1:0] offset);
        logic [7:0]  b;
        logic [15:0] h;
        word_t       r;
        case (offset)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = offset[1] ? raw[31:16] : raw[15:0];
        case (f3)
            LB:      r = {{24{b[7]}}, b};
            LH:      r = {{16{h[15]}}, h};
            LBU:     r = {24'h0, b};
            LHU:     r = {16'h0, h};
            default: r = raw;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO of writeback requests; head is read from storage so a
// pushed entry becomes visible the cycle after its push.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  din,
    input  logic                     pop,
    output wb_req_t                  dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between EXU results and buffered LSU loads
// into one registered regfile write port. WB_BYPASS_EN adds fwd_* outputs.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int LSU_FIFO_DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              exu_valid,
    output logic                              exu_ready,
    input  logic [4:0]                        exu_rd,
    input  logic [31:0]                       exu_wdata,
    input  logic                              lsu_valid,
    output logic                              lsu_ready,
    input  logic [4:0]                        lsu_rd,
    input  logic [31:0]                       lsu_rdata,
    input  logic [2:0]                        lsu_funct3,
    input  logic [1:0]                        lsu_offset,
    output logic                              rf_we,
    output logic [4:0]                        rf_rd,
    output logic [31:0]                       rf_wdata,
    output logic [$clog2(LSU_FIFO_DEPTH):0]   lsu_count
`ifdef WB_BYPASS_EN
    ,
    output logic                              fwd_valid,
    output logic [4:0]                        fwd_rd,
    output logic [31:0]                       fwd_wdata
`endif
);

    wb_req_t push_req;
    wb_req_t head;
    logic    fifo_full;
    logic    fifo_empty;
    logic    grant_exu;
    logic    grant_lsu;
    logic    last_grant_lsu;

    assign push_req.rd   = lsu_rd;
    assign push_req.data = load_extend(lsu_rdata, load_f3_t'(lsu_funct3), lsu_offset);

    wb_fifo #(
        .DEPTH (LSU_FIFO_DEPTH)
    ) u_lsu_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_valid),
        .din   (push_req),
        .pop   (grant_lsu),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (lsu_count)
    );

    assign lsu_ready = !fifo_full;

    // On a tie the side that lost last time wins.
    assign grant_exu = exu_valid && (fifo_empty || last_grant_lsu);
    assign grant_lsu = !fifo_empty && (!exu_valid || !last_grant_lsu);
    assign exu_ready = grant_exu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we          <= 1'b0;
            rf_rd          <= '0;
            rf_wdata       <= '0;
            last_grant_lsu <= 1'b1;
        end else begin
            rf_we <= 1'b0;
            if (grant_exu) begin
                rf_rd    <= exu_rd;
                rf_wdata <= exu_wdata;
                rf_we    <= (exu_rd != '0);
            end else if (grant_lsu) begin
                rf_rd    <= head.rd;
                rf_wdata <= head.data;
                rf_we    <= (head.rd != '0);
            end
            if (grant_exu || grant_lsu) begin
                last_grant_lsu <= grant_lsu;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign fwd_valid = rf_we;
    assign fwd_rd    = rf_rd;
    assign fwd_wdata = rf_wdata;
`endif

endmodule
